car_cmd_uart_tx: RTL

//   UART transmitter carrying car motion/barrier commands from the FPGA to the PC-side car

---
 rtl/car_cmd_uart_tx.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/car_cmd_uart_tx.sv
`default_nettype none
// =============================================================================
// car_cmd_uart_tx : 8N1 transmitter for car motion/barrier command bytes
// Revision 1.0
// =============================================================================
module car_cmd_uart_tx #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int BAUD           = 9600,
  parameter int REFRESH_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic move_forward,
  input  logic move_backward,
  input  logic turn_left,
  input  logic turn_right,
  input  logic place_barrier,
  input  logic destroy_barrier,
  output logic tx,
  output logic busy,
  output logic frame_sent
);

  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int BAUD_W  = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int REF_W   = $clog2(REFRESH_CYCLES);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYC - 1);
  localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_CYCLES - 1);
  localparam logic [7:0]        RST_SNAP  = 8'h80;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [REF_W-1:0]  refresh_q, refresh_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        last_q, last_d;
  logic              place_q, place_d;
  logic              destroy_q, destroy_d;
  logic              tx_q, tx_d;

  logic [7:0] cmd_byte;
  logic       trigger;
  logic       bit_end;

  assign cmd_byte = {2'b10, destroy_q, place_q, turn_right, turn_left,
                     move_backward, move_forward};
  assign trigger  = (cmd_byte != last_q) | place_q | destroy_q |
                    (refresh_q == REF_LAST);
  assign bit_end  = (baud_q == BAUD_LAST);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    refresh_d = refresh_q;
    shift_d   = shift_q;
    last_d    = last_q;
    tx_d      = tx_q;
    // Pulses arriving while a frame is in flight stay pending for the next one.
    place_d   = place_q | place_barrier;
    destroy_d = destroy_q | destroy_barrier;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        if (trigger) begin
          state_d   = S_START;
          shift_d   = cmd_byte;
          last_d    = cmd_byte;
          refresh_d = '0;
          tx_d      = 1'b0;
          place_d   = place_barrier;
          destroy_d = destroy_barrier;
        end else if (refresh_q != REF_LAST) begin
          refresh_d = refresh_q + 1'b1;
        end
      end
      S_START: begin
        baud_d = bit_end ? '0 : baud_q + 1'b1;
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        baud_d = bit_end ? '0 : baud_q + 1'b1;
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      S_STOP: begin
        baud_d = bit_end ? '0 : baud_q + 1'b1;
        tx_d   = 1'b1;
        if (bit_end) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      refresh_q <= '0;
      shift_q   <= '0;
      last_q    <= RST_SNAP;
      place_q   <= 1'b0;
      destroy_q <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      refresh_q <= refresh_d;
      shift_q   <= shift_d;
      last_q    <= last_d;
      place_q   <= place_d;
      destroy_q <= destroy_d;
      tx_q      <= tx_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_sent = (state_q == S_STOP) && bit_end;

endmodule
`default_nettype wire
